timing_decoder: RTL and testbench

TIMING_DECODER -- requirements
Module: timing_decoder

---
 rtl/timing_decoder_pkg.sv | 18 +
 rtl/timing_decoder_onehot_decoder.sv | 15 +
 rtl/timing_decoder.sv | 100 ++++++++++
 tb/tb_timing_decoder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/timing_decoder_pkg.sv
// Shared types and parameter checks for the timing_decoder step sequencer.
package timing_decoder_pkg;

  // Per-cycle command, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    CMD_RST,
    CMD_CLR,
    CMD_LD,
    CMD_ADV,
    CMD_HOLD
  } cmd_e;

  function automatic bit params_legal(input int w, input int depth, input int wrap);
    return (w >= 1) && (w <= 16) && (depth >= 2) && (depth <= (1 << w)) &&
           ((wrap == 0) || (wrap == 1));
  endfunction

endpackage

// File: rtl/timing_decoder_onehot_decoder.sv
// Binary index to one-hot conversion; output is all-zero when en is low.
module onehot_decoder #(
  parameter int W = 3
) (
  input  logic [W-1:0]      idx,
  input  logic              en,
  output logic [(1<<W)-1:0] o
);

  always_comb begin
    o = '0;
    if (en) o[idx] = 1'b1;
  end

endmodule

// File: rtl/timing_decoder.sv
// Step sequencer with registered step index, one-hot timing strobes,
// terminal-count pulse (cyclic mode) and completion level (one-shot mode).
module timing_decoder
  import timing_decoder_pkg::*;
#(
  parameter int W     = 3,
  parameter int DEPTH = 8,
  parameter int WRAP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_n,
  input  logic              clr,
  input  logic              ld,
  input  logic [W-1:0]      ld_idx,
  output logic [W-1:0]      step,
  output logic [(1<<W)-1:0] t,
  output logic              tc,
  output logic              done,
  output logic              ld_err
);

  generate
    if (!params_legal(W, DEPTH, WRAP)) begin : g_bad_params
      $error("timing_decoder: illegal parameters W=%0d DEPTH=%0d WRAP=%0d", W, DEPTH, WRAP);
    end
  endgenerate

  localparam logic [W-1:0] LAST   = W'(DEPTH - 1);
  localparam logic [W:0]   DEPTHX = (W+1)'(DEPTH);
  localparam logic [(1<<W)-1:0] T_RST = {{((1<<W)-1){1'b0}}, 1'b1};

  logic [W-1:0]      r_step;
  logic [(1<<W)-1:0] r_t;
  logic              r_tc;
  logic              r_done;
  logic              r_ld_err;

  cmd_e              w_cmd;
  logic              w_ld_ok;
  logic              w_at_last;
  logic [W-1:0]      w_step_nxt;
  logic [(1<<W)-1:0] w_t_nxt;

  // Compare in W+1 bits so DEPTH == 2**W does not overflow.
  assign w_ld_ok   = ({1'b0, ld_idx} < DEPTHX);
  assign w_at_last = (r_step == LAST);

  always_comb begin
    w_cmd = CMD_HOLD;
    if (rst)        w_cmd = CMD_RST;
    else if (clr)   w_cmd = CMD_CLR;
    else if (ld)    w_cmd = CMD_LD;
    else if (!en_n) w_cmd = CMD_ADV;
  end

  always_comb begin
    w_step_nxt = r_step;
    case (w_cmd)
      CMD_RST, CMD_CLR: w_step_nxt = '0;
      CMD_LD:           if (w_ld_ok) w_step_nxt = ld_idx;
      CMD_ADV: begin
        if (!w_at_last)     w_step_nxt = r_step + W'(1);
        else if (WRAP == 1) w_step_nxt = '0;
        else                w_step_nxt = LAST;
      end
      default:          w_step_nxt = r_step;
    endcase
  end

  onehot_decoder #(.W(W)) u_onehot (
    .idx (w_step_nxt),
    .en  (1'b1),
    .o   (w_t_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_step   <= '0;
      r_t      <= T_RST;
      r_tc     <= 1'b0;
      r_done   <= 1'b0;
      r_ld_err <= 1'b0;
    end else begin
      r_step   <= w_step_nxt;
      r_t      <= w_t_nxt;
      // tc marks only a wrap caused by advancing, never a clr/ld to 0.
      r_tc     <= (WRAP == 1) && (w_cmd == CMD_ADV) && w_at_last;
      r_done   <= (WRAP == 0) && (w_step_nxt == LAST);
      r_ld_err <= (w_cmd == CMD_LD) && !w_ld_ok;
    end
  end

  assign step   = r_step;
  assign t      = r_t;
  assign tc     = r_tc;
  assign done   = r_done;
  assign ld_err = r_ld_err;

endmodule

// File: tb/tb_timing_decoder.sv
// Directed bench for timing_decoder: three instances (cyclic depth 8,
// cyclic depth 6, one-shot depth 5) driven from shared inputs.
module tb_timing_decoder;

  logic       clk = 1'b0;
  logic       rst, en_n, clr, ld;
  logic [2:0] ld_idx;

  logic [2:0] step8, step6, step5;
  logic [7:0] t8, t6, t5;
  logic       tc8, tc6, tc5, done8, done6, done5, err8, err6, err5;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  timing_decoder #(.W(3), .DEPTH(8), .WRAP(1)) u8 (
    .clk(clk), .rst(rst), .en_n(en_n), .clr(clr), .ld(ld), .ld_idx(ld_idx),
    .step(step8), .t(t8), .tc(tc8), .done(done8), .ld_err(err8));

  timing_decoder #(.W(3), .DEPTH(6), .WRAP(1)) u6 (
    .clk(clk), .rst(rst), .en_n(en_n), .clr(clr), .ld(ld), .ld_idx(ld_idx),
    .step(step6), .t(t6), .tc(tc6), .done(done6), .ld_err(err6));

  timing_decoder #(.W(3), .DEPTH(5), .WRAP(0)) u5 (
    .clk(clk), .rst(rst), .en_n(en_n), .clr(clr), .ld(ld), .ld_idx(ld_idx),
    .step(step5), .t(t5), .tc(tc5), .done(done5), .ld_err(err5));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Apply inputs, take one edge, then sample 1 time unit later.
  task automatic tick(input logic i_rst, input logic i_en_n, input logic i_clr,
                      input logic i_ld, input logic [2:0] i_idx);
    rst = i_rst; en_n = i_en_n; clr = i_clr; ld = i_ld; ld_idx = i_idx;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  initial begin
    logic [7:0] one = 8'd1;
    rst = 1'b1; en_n = 1'b1; clr = 1'b0; ld = 1'b0; ld_idx = '0;

    // Reset state
    do_reset();
    check("rst_step8", step8, 0);
    check("rst_t8",    t8,    8'h01);
    check("rst_tc8",   tc8,   0);
    check("rst_err8",  err8,  0);
    check("rst_done5", done5, 0);
    check("rst_t5",    t5,    8'h01);

    // Hold with en_n=1
    tick(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
    check("hold_step8", step8, 0);

    // Cyclic depth 8: eight advances return to 0 with tc, then continue
    for (int k = 1; k <= 9; k++) begin
      adv(1);
      check($sformatf("cyc8_step_%0d", k), step8, k % 8);
      check($sformatf("cyc8_t_%0d", k),    t8,    one << (k % 8));
      check($sformatf("cyc8_tc_%0d", k),   tc8,   (k == 8) ? 1 : 0);
      check($sformatf("cyc8_done_%0d", k), done8, 0);
    end

    // Depth 6: rejected load at step 2, then wrap 3,4,5,0
    do_reset();
    adv(2);
    check("d6_pre_step", step6, 2);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 3'd6);
    check("d6_badld_step", step6, 2);
    check("d6_badld_err",  err6,  1);
    check("d8_goodld_err", err8,  0);
    check("d8_goodld_step", step8, 6);
    for (int k = 0; k < 4; k++) begin
      adv(1);
      check($sformatf("d6_step_%0d", k), step6, (k == 3) ? 0 : 3 + k);
      check($sformatf("d6_t_%0d", k),    t6,    (k == 3) ? 8'h01 : (one << (3 + k)));
      check($sformatf("d6_err_%0d", k),  err6,  0);
      check($sformatf("d6_tc_%0d", k),   tc6,   (k == 3) ? 1 : 0);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b1, 3'd7);
    check("d6_badld7_err",  err6,  1);
    check("d6_badld7_step", step6, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 3'd5);
    check("d6_ld5_step", step6, 5);
    check("d6_ld5_t",    t6,    8'h20);
    check("d6_ld5_err",  err6,  0);

    // One-shot depth 5: saturate at 4 with done level, tc tied low
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      adv(1);
      check($sformatf("d5_step_%0d", k), step5, (k < 4) ? k : 4);
      check($sformatf("d5_t_%0d", k),    t5,    one << ((k < 4) ? k : 4));
      check($sformatf("d5_done_%0d", k), done5, (k >= 4) ? 1 : 0);
      check($sformatf("d5_tc_%0d", k),   tc5,   0);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b1, 3'd1);
    check("d5_ld1_done", done5, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 3'd4);
    check("d5_ld4_done", done5, 1);

    // clr beats ld; ld beats advance
    do_reset();
    adv(5);
    check("cl_pre_step", step8, 5);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 3'd3);
    check("cl_step",  step8, 0);
    check("cl_err",   err8,  0);
    check("cl_tc",    tc8,   0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 3'd3);
    check("ld_step",  step8, 3);
    check("ld_t",     t8,    8'h08);

    // clr or ld to 0 from step 7 must not raise tc
    tick(1'b0, 1'b1, 1'b0, 1'b1, 3'd7);
    check("ld7_step", step8, 7);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 3'd0);
    check("ld0_step", step8, 0);
    check("ld0_tc",   tc8,   0);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 3'd7);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
    check("clr7_step", step8, 0);
    check("clr7_tc",   tc8,   0);

    // rst mid-sequence overrides advance, then sequence resumes
    do_reset();
    adv(6);
    check("mr_pre_step", step8, 6);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
    check("mr_step",  step8, 0);
    check("mr_t",     t8,    8'h01);
    check("mr_tc",    tc8,   0);
    check("mr_done5", done5, 0);
    adv(1);
    check("mr_res1",  step8, 1);
    adv(1);
    check("mr_res2",  step8, 2);
    check("mr_res2_t", t8,   8'h04);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
